vga_scan_ctrl: RTL and testbench
================================

Name: vga_scan_ctrl

Overview:
- Scan-out side of the VGA framebuffer: generates 640x480@60 timing and drives `h_addr`/`v_addr` into the framebuffer read port.
- Captures the returned 12-bit `vga_data` and drives sync, blank and RGB to the VGA pins, with sync and blank delayed to match framebuffer read latency.
- Provides `frame_start` and `vblank` status to the CPU/MMIO side so software can time framebuffer updates.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- PIX_DIV, 4, system clocks per pixel; 100 MHz to 25 MHz
- RD_LAT, 1, framebuffer read latency in clocks; must satisfy 1 <= RD_LAT < PIX_DIV

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- en  in  1  scan enable
- h_addr  out  10  active column to framebuffer; 0 outside active area
- v_addr  out  10  active row to framebuffer; 0 outside active area
- vga_data  in  12  framebuffer pixel, RGB444, valid RD_LAT clocks after address
- vga_hs  out  1  hsync, active-low
- vga_vs  out  1  vsync, active-low
- vga_blank_n  out  1  1 = active video at pins
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue
- frame_start  out  1  one-clock pulse at start of each frame
- vblank  out  1  level, 1 while v_cnt >= V_ACTIVE

Behaviour:
- Reset (reset==0 at posedge):
  - Counters: div=0, h_cnt=0, v_cnt=0.
  - Outputs: vga_hs=1, vga_vs=1, vga_blank_n=0, RGB=0, frame_start=0, vblank=0.
  - Delay pipeline cleared to the inactive state (hs=1, vs=1, active=0).
  - Reset mid-frame takes effect immediately; no frame completion.
- en==0: same counter, pipeline and output state as reset, held while low. Scanning resumes from (0,0) on the first clock with en==1.
- Pixel enable: div counts 0..PIX_DIV-1 and wraps. pix_en = (div==PIX_DIV-1).
- Horizontal counter: on pix_en, h_cnt increments and wraps at H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
- Vertical counter: on h_cnt wrap, v_cnt increments and wraps at V_TOTAL (525).
- Region order per axis: active, front porch, sync, back porch.
- Raw timing, combinational from the counters:
  - active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE
  - hs_raw low for h_cnt in [656,752)
  - vs_raw low for v_cnt in [490,492)
- Addresses: h_addr/v_addr = h_cnt/v_cnt when active, else 0. Each address is held stable for PIX_DIV clocks.
- Alignment pipeline: {active, hs_raw, vs_raw} pass through an RD_LAT-stage shift register clocked every clock (not gated by pix_en).
- Output register, every clock:
  - vga_hs, vga_vs, vga_blank_n take the delayed values.
  - {vga_r, vga_g, vga_b} = vga_data[11:8], [7:4], [3:0] when delayed active, else 0.
  - Total latency from counters to pins: RD_LAT+1 clocks, identical for sync, blank and data.
- Blanking: RGB is forced to 0 whenever vga_blank_n==0, regardless of vga_data.
- frame_start: registered, high for exactly one clock on the pix_en cycle where h_cnt and v_cnt both wrap to 0. Not asserted on the reset/enable entry into (0,0).
- vblank: registered from v_cnt >= V_ACTIVE. Rises one clock after v_cnt reaches 480; falls one clock after v_cnt wraps to 0.
- Widths: counters are 10 bits; V_TOTAL-1 = 524 fits. v_addr[9] is always 0 in active area (framebuffer uses v_addr[8:0]).
- Framebuffer interaction: no stall or handshake. The framebuffer read port is free-running, so scan-out never waits on CPU writes.

Decomposition:
- Package vga_pkg:
  - Timing defaults: H_*/V_*, H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END.
  - typedef coord_t (10-bit), typedef rgb444_t (12-bit), localparam PIX_DIV_DEFAULT.
- Sub-module vga_axis_counter: parameterised wrap counter with increment enable. Outputs count, wrap, in_active, in_sync. Instantiated twice (h and v).

Test Plan:
- Reset/idle: hold reset=0 for 10 clocks with vga_data=12'hFFF -> vga_hs=vga_vs=1, vga_blank_n=0, RGB=0, frame_start=0, vblank=0, h_addr=v_addr=0.
- Line timing: run 1 line -> vga_hs low for exactly 384 clocks (96x4), starting 2624 clocks (656x4, plus RD_LAT+1) after release. Line period 3200 clocks. vga_blank_n high for 2560 clocks per visible line.
- Frame timing: run 2 frames -> frame_start pulses exactly 1,680,000 clocks apart, each 1 clock wide. vga_vs low for 6400 clocks (2 lines). vblank high for 45 lines = 144,000 clocks.
- Data alignment: framebuffer model with RD_LAT=1 returning {h_addr[3:0], v_addr[3:0], 4'hA} -> pixel (5,3) shows r=5, g=3, b=A for 4 clocks, coincident with vga_blank_n. Pixel (639,479) shows r=F, g=F, b=A.
- Blank masking: vga_data forced to 12'hFFF throughout -> RGB=0 in every clock where vga_blank_n==0; h_addr=v_addr=0 whenever h_cnt>=640 or v_cnt>=480.
- Mid-frame reset/enable: deassert en at line 200 for 50 clocks, then reassert -> outputs go to reset state within 1 clock, no frame_start at re-entry. First hsync occurs 2624+RD_LAT+1 clocks after re-enable. Repeat using reset=0 -> identical response.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, coordinate and pixel types for the scan-out path.
package vga_pkg;

   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;

   localparam int PIX_DIV_DEFAULT = 4;
   localparam int RD_LAT_DEFAULT  = 1;

   localparam int COORD_W = 10;
   typedef logic [COORD_W-1:0] coord_t;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   // One slot of the sync/blank alignment pipeline; syncs are active-low.
   typedef struct packed {
      logic active;
      logic hs;
      logic vs;
   } timing_t;

   localparam timing_t TIMING_IDLE = '{active: 1'b0, hs: 1'b1, vs: 1'b1};

   function automatic logic in_range(coord_t x, coord_t lo, coord_t hi);
      return (x >= lo) && (x < hi);
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping position counter for one scan axis; flags the active and sync regions.
module vga_axis_counter #(
   parameter int ACTIVE = 640,
   parameter int FP     = 16,
   parameter int SYNC   = 96,
   parameter int BP     = 48
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       en,
   input  logic       inc,
   output logic [9:0] count,
   output logic       wrap,
   output logic       in_active,
   output logic       in_sync
);
   import vga_pkg::*;

   localparam coord_t LAST       = coord_t'(ACTIVE + FP + SYNC + BP - 1);
   localparam coord_t ACT_END    = coord_t'(ACTIVE);
   localparam coord_t SYNC_START = coord_t'(ACTIVE + FP);
   localparam coord_t SYNC_END   = coord_t'(ACTIVE + FP + SYNC);

   coord_t count_reg;
   coord_t count_next;
   logic   at_last;

   assign at_last = (count_reg == LAST);

   always_comb begin
      count_next = count_reg;
      if (inc) begin
         count_next = at_last ? '0 : count_reg + coord_t'(1);
      end
   end

   // Disabling the scan parks the axis at zero, same as reset.
   always_ff @(posedge clock) begin
      if (!reset || !en) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   assign count     = count_reg;
   assign wrap      = inc && at_last;
   assign in_active = (count_reg < ACT_END);
   assign in_sync   = in_range(count_reg, SYNC_START, SYNC_END);

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan-out: pixel timing, framebuffer addressing, latency-matched sync/blank
// and RGB pin registers, plus frame_start/vblank status for software.
module vga_scan_ctrl #(
   parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
   parameter int H_FP     = vga_pkg::H_FP,
   parameter int H_SYNC   = vga_pkg::H_SYNC,
   parameter int H_BP     = vga_pkg::H_BP,
   parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
   parameter int V_FP     = vga_pkg::V_FP,
   parameter int V_SYNC   = vga_pkg::V_SYNC,
   parameter int V_BP     = vga_pkg::V_BP,
   parameter int PIX_DIV  = vga_pkg::PIX_DIV_DEFAULT,
   parameter int RD_LAT   = vga_pkg::RD_LAT_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        en,
   output logic [9:0]  h_addr,
   output logic [9:0]  v_addr,
   input  logic [11:0] vga_data,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        vga_blank_n,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        frame_start,
   output logic        vblank
);
   import vga_pkg::*;

   localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

   // ---------------- pixel clock enable ----------------
   logic [DIV_W-1:0] div_reg;
   logic [DIV_W-1:0] div_next;
   logic             pix_en;

   assign pix_en = (div_reg == DIV_LAST);

   always_comb begin
      div_next = pix_en ? '0 : div_reg + DIV_W'(1);
   end

   always_ff @(posedge clock) begin
      if (!reset || !en) begin
         div_reg <= '0;
      end else begin
         div_reg <= div_next;
      end
   end

   // ---------------- scan position ----------------
   logic [9:0] h_cnt;
   logic [9:0] v_cnt;
   logic       h_wrap;
   logic       v_wrap;
   logic       h_act;
   logic       v_act;
   logic       h_sync;
   logic       v_sync;

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP)
   ) u_h_axis (
      .clock     (clock),
      .reset     (reset),
      .en        (en),
      .inc       (pix_en),
      .count     (h_cnt),
      .wrap      (h_wrap),
      .in_active (h_act),
      .in_sync   (h_sync)
   );

   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP)
   ) u_v_axis (
      .clock     (clock),
      .reset     (reset),
      .en        (en),
      .inc       (h_wrap),
      .count     (v_cnt),
      .wrap      (v_wrap),
      .in_active (v_act),
      .in_sync   (v_sync)
   );

   // ---------------- raw timing and framebuffer address ----------------
   timing_t raw;

   always_comb begin
      raw        = TIMING_IDLE;
      raw.active = h_act && v_act;
      raw.hs     = !h_sync;
      raw.vs     = !v_sync;
   end

   assign h_addr = raw.active ? h_cnt : '0;
   assign v_addr = raw.active ? v_cnt : '0;

   // ---------------- alignment pipeline (every clock, not per pixel) ----------------
   timing_t [RD_LAT-1:0] pipe_reg;
   timing_t [RD_LAT-1:0] pipe_next;

   for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
         assign pipe_next[gi] = raw;
      end else begin : g_tail
         assign pipe_next[gi] = pipe_reg[gi-1];
      end
   end

   always_ff @(posedge clock) begin
      if (!reset || !en) begin
         pipe_reg <= {RD_LAT{TIMING_IDLE}};
      end else begin
         pipe_reg <= pipe_next;
      end
   end

   // ---------------- pin registers ----------------
   timing_t dly;
   rgb444_t pix_in;
   rgb444_t rgb_reg;
   rgb444_t rgb_next;
   logic    hs_reg;
   logic    vs_reg;
   logic    blank_n_reg;
   logic    frame_start_reg;
   logic    vblank_reg;

   assign dly    = pipe_reg[RD_LAT-1];
   assign pix_in = rgb444_t'(vga_data);

   // Masking on the delayed flag keeps porch/sync pixels black whatever the RAM returns.
   always_comb begin
      rgb_next = '0;
      if (dly.active) begin
         rgb_next = pix_in;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset || !en) begin
         hs_reg          <= 1'b1;
         vs_reg          <= 1'b1;
         blank_n_reg     <= 1'b0;
         rgb_reg         <= '0;
         frame_start_reg <= 1'b0;
         vblank_reg      <= 1'b0;
      end else begin
         hs_reg          <= dly.hs;
         vs_reg          <= dly.vs;
         blank_n_reg     <= dly.active;
         rgb_reg         <= rgb_next;
         frame_start_reg <= v_wrap;
         vblank_reg      <= !v_act;
      end
   end

   assign vga_hs      = hs_reg;
   assign vga_vs      = vs_reg;
   assign vga_blank_n = blank_n_reg;
   assign vga_r       = rgb_reg.r;
   assign vga_g       = rgb_reg.g;
   assign vga_b       = rgb_reg.b;
   assign frame_start = frame_start_reg;
   assign vblank      = vblank_reg;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Scoreboard bench: two scan controllers (full 640x480 timing and a tiny screen)
// checked every clock against an arithmetic model of the scan position.
module tb_vga_scan_ctrl;

   logic clock;
   logic reset;
   logic en;

   int checks;
   int errors;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
      localparam int HA = (gi == 0) ? 640 : 8;
      localparam int HF = (gi == 0) ? 16  : 2;
      localparam int HS = (gi == 0) ? 96  : 3;
      localparam int HB = (gi == 0) ? 48  : 2;
      localparam int VA = (gi == 0) ? 480 : 6;
      localparam int VF = (gi == 0) ? 10  : 2;
      localparam int VS = (gi == 0) ? 2   : 2;
      localparam int VB = (gi == 0) ? 33  : 3;
      localparam int PD = (gi == 0) ? 4   : 3;
      localparam int RL = (gi == 0) ? 1   : 2;
      localparam int HT = HA + HF + HS + HB;
      localparam int VT = VA + VF + VS + VB;

      logic [9:0]  h_addr;
      logic [9:0]  v_addr;
      logic [11:0] vga_data;
      logic        vga_hs;
      logic        vga_vs;
      logic        vga_blank_n;
      logic [3:0]  vga_r;
      logic [3:0]  vga_g;
      logic [3:0]  vga_b;
      logic        frame_start;
      logic        vblank;

      vga_scan_ctrl #(
         .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
         .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
         .PIX_DIV  (PD), .RD_LAT (RL)
      ) u_dut (
         .clock       (clock),
         .reset       (reset),
         .en          (en),
         .h_addr      (h_addr),
         .v_addr      (v_addr),
         .vga_data    (vga_data),
         .vga_hs      (vga_hs),
         .vga_vs      (vga_vs),
         .vga_blank_n (vga_blank_n),
         .vga_r       (vga_r),
         .vga_g       (vga_g),
         .vga_b       (vga_b),
         .frame_start (frame_start),
         .vblank      (vblank)
      );

      // Framebuffer: random contents indexed by the low address bits, RL-clock read.
      // Entry 0 is all-ones so blanked cycles (address 0) stress the RGB masking.
      logic [11:0] fb_mem [256];
      logic [11:0] fb_q [RL];

      initial begin
         for (int i = 0; i < 256; i++) fb_mem[i] = 12'($urandom);
         fb_mem[0]     = 12'hFFF;
         fb_mem[8'h35] = 12'h53A;
         fb_mem[8'hFF] = 12'hFFA;
      end

      always @(posedge clock) begin
         fb_q[0] <= fb_mem[{v_addr[3:0], h_addr[3:0]}];
         for (int i = 1; i < RL; i++) fb_q[i] <= fb_q[i-1];
      end

      assign vga_data = fb_q[RL-1];

      // Expected pins after c enabled clocks since the last reset/disable clock.
      // Counters after c clocks sit at pixel c/PD; pins lag the counters by RL+1.
      function automatic logic [36:0] model(int c);
         int pix, h, v, d;
         logic [9:0]  ha, va;
         logic        hs, vs, bn, fs, vb;
         logic [11:0] rgb;
         ha = '0; va = '0; hs = 1'b1; vs = 1'b1; bn = 1'b0; fs = 1'b0; vb = 1'b0; rgb = '0;
         pix = c / PD;
         h   = pix % HT;
         v   = (pix / HT) % VT;
         if (h < HA && v < VA) begin
            ha = 10'(h);
            va = 10'(v);
         end
         d = c - 1 - RL;
         if (d >= 0) begin
            pix = d / PD;
            h   = pix % HT;
            v   = (pix / HT) % VT;
            hs  = !(h >= HA + HF && h < HA + HF + HS);
            vs  = !(v >= VA + VF && v < VA + VF + VS);
            bn  = (h < HA) && (v < VA);
            if (bn) rgb = fb_mem[{v[3:0], h[3:0]}];
         end
         fs = (c > 0) && (c % (PD * HT * VT) == 0);
         if (c > 0) begin
            pix = (c - 1) / PD;
            v   = (pix / HT) % VT;
            vb  = (v >= VA);
         end
         return {ha, va, hs, vs, bn, rgb, fs, vb};
      endfunction

      logic [36:0] exp_q [$];
      int          cnt;

      // Stimulus side: every clock edge issues one expected pin state.
      initial begin
         cnt = 0;
         forever begin
            @(posedge clock);
            if (!reset || !en) cnt = 0;
            else cnt = cnt + 1;
            exp_q.push_back(model(cnt));
         end
      end

      // Monitor side: pins are presented every clock; compare mid-cycle.
      initial begin
         logic [36:0] e;
         logic [36:0] a;
         forever begin
            @(negedge clock);
            a = {h_addr, v_addr, vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b,
                 frame_start, vblank};
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL cfg%0d scoreboard_empty got %h required an expected entry", gi, a);
            end else begin
               e = exp_q.pop_front();
               if (a !== e) begin
                  errors++;
                  $display("FAIL cfg%0d pins t=%0t got ha=%0d va=%0d hs=%b vs=%b bn=%b rgb=%h fs=%b vb=%b required ha=%0d va=%0d hs=%b vs=%b bn=%b rgb=%h fs=%b vb=%b",
                           gi, $time, a[36:27], a[26:17], a[16], a[15], a[14], a[13:2], a[1], a[0],
                           e[36:27], e[26:17], e[16], e[15], e[14], e[13:2], e[1], e[0]);
               end
            end
         end
      end
   end

   // mode 1 drops en, mode 2 pulls reset low, for n_off clocks after n_run clocks.
   task automatic run_seg(input string name, input int n_run, input int mode, input int n_off);
      reset = 1'b1;
      en    = 1'b1;
      repeat (n_run) @(negedge clock);
      if (mode == 1) en = 1'b0;
      else reset = 1'b0;
      repeat (n_off) @(negedge clock);
      reset = 1'b1;
      en    = 1'b1;
      $display("SEG %s run=%0d mode=%0d off=%0d checks=%0d errors=%0d",
               name, n_run, mode, n_off, checks, errors);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      en     = 1'b1;
      repeat (10) @(negedge clock);
      $display("SEG reset_hold run=0 mode=2 off=10 checks=%0d errors=%0d", checks, errors);
      run_seg("lines_then_en_low", 11000, 1, 50);
      run_seg("resume_then_reset", 3500, 2, 50);
      run_seg("resume_then_en_pulse", 3500, 1, 1);
      for (int k = 0; k < 12; k++) begin
         run_seg("random", int'($urandom_range(20, 2600)), int'($urandom_range(1, 2)),
                 int'($urandom_range(1, 8)));
      end
      run_seg("tail", 3000, 1, 2);
      repeat (2) @(negedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
